// File: rtl/iomem_timer_if.sv
// iomem bus bundle between the SoC initiator port and a responder peripheral.
// Initiator holds valid/addr/wdata/wstrb stable until the one-cycle ready pulse.
interface iomem_timer_if;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    output iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    input  iomem_ready, iomem_rdata
  );

  modport slave (
    input  iomem_valid, iomem_wstrb, iomem_addr, iomem_wdata,
    output iomem_ready, iomem_rdata
  );
endinterface

// File: rtl/iomem_timer.sv
// iomem responder: 32-bit down-counting timer with irq plus 2-bit LED register; IOMEM_TIMER_PRESCALER_EN adds PRESCALE at 0x10.
// Latency: every selected access acknowledged one cycle after select, rdata registered alongside ready.
// Backpressure: none; initiator holds the request until ready, so back-to-back accesses complete every 2 cycles.
module iomem_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic          clk,
  input  logic          reset,
  iomem_timer_if.slave  bus,
  output logic          irq,
  output logic          led1,
  output logic          led2
);

  localparam logic [5:0] OFF_CTRL   = 6'h00;
  localparam logic [5:0] OFF_LOAD   = 6'h01;
  localparam logic [5:0] OFF_COUNT  = 6'h02;
  localparam logic [5:0] OFF_STATUS = 6'h03;
  localparam logic [5:0] OFF_PRESC  = 6'h04;

  function automatic logic [31:0] byte_merge(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  logic        ready_q;
  logic [31:0] rdata_q;
  logic        ctrl_en;
  logic        ctrl_reload;
  logic        ctrl_irq_en;
  logic [1:0]  ctrl_led;
  logic [31:0] load_q;
  logic [31:0] count_q;
  logic [31:0] count_d;
  logic        expired_q;
  logic        expire;
  logic        tick;
  logic [31:0] rd_mux;

  logic       sel;
  logic       acc;
  logic       wr;
  logic [5:0] off;
  logic       wr_ctrl;
  logic       wr_load;
  logic       wr_count;
  logic       w1c_status;
  logic       unused_addr_lsb;

  assign sel = bus.iomem_valid && (bus.iomem_addr[31:8] == BASE_ADDR[31:8]);
  // The cycle that raises ready is the only one that commits a write or samples a read.
  assign acc = sel && !ready_q;
  assign wr  = acc && (bus.iomem_wstrb != 4'b0000);
  assign off = bus.iomem_addr[7:2];
  assign unused_addr_lsb = ^bus.iomem_addr[1:0];

  assign wr_ctrl    = wr && (off == OFF_CTRL);
  assign wr_load    = wr && (off == OFF_LOAD);
  assign wr_count   = wr && (off == OFF_COUNT);
  assign w1c_status = wr && (off == OFF_STATUS) && bus.iomem_wstrb[0] && bus.iomem_wdata[0];

`ifdef IOMEM_TIMER_PRESCALER_EN
  logic [15:0] presc_q;
  logic [15:0] pcnt_q;
  logic        wr_presc;

  assign wr_presc = wr && (off == OFF_PRESC);
  assign tick     = ctrl_en && (pcnt_q == presc_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= 16'h0;
      pcnt_q  <= 16'h0;
    end else begin
      if (wr_presc && bus.iomem_wstrb[0]) presc_q[7:0]  <= bus.iomem_wdata[7:0];
      if (wr_presc && bus.iomem_wstrb[1]) presc_q[15:8] <= bus.iomem_wdata[15:8];
      if (wr_presc || !ctrl_en || tick) pcnt_q <= 16'h0;
      else                              pcnt_q <= pcnt_q + 16'h1;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // A COUNT write replaces the whole step on its edge, expiry included.
  always_comb begin
    count_d = count_q;
    expire  = 1'b0;
    if (tick && ctrl_en && (count_q != 32'h0)) begin
      if (count_q == 32'h1) begin
        expire  = 1'b1;
        count_d = ctrl_reload ? load_q : 32'h0;
      end else begin
        count_d = count_q - 32'h1;
      end
    end
    if (wr_count) begin
      count_d = byte_merge(count_q, bus.iomem_wdata, bus.iomem_wstrb);
      expire  = 1'b0;
    end
  end

  always_comb begin
    rd_mux = 32'h0;
    case (off)
      OFF_CTRL:   rd_mux = {26'h0, ctrl_led, 1'b0, ctrl_irq_en, ctrl_reload, ctrl_en};
      OFF_LOAD:   rd_mux = load_q;
      OFF_COUNT:  rd_mux = count_q;
      OFF_STATUS: rd_mux = {31'h0, expired_q};
`ifdef IOMEM_TIMER_PRESCALER_EN
      OFF_PRESC:  rd_mux = {16'h0, presc_q};
`endif
      default:    rd_mux = 32'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_q     <= 1'b0;
      rdata_q     <= 32'h0;
      ctrl_en     <= 1'b0;
      ctrl_reload <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_led    <= 2'b00;
      load_q      <= 32'h0;
      count_q     <= 32'h0;
      expired_q   <= 1'b0;
    end else begin
      ready_q <= acc;
      rdata_q <= acc ? rd_mux : 32'h0;
      if (wr_ctrl && bus.iomem_wstrb[0]) begin
        ctrl_en     <= bus.iomem_wdata[0];
        ctrl_reload <= bus.iomem_wdata[1];
        ctrl_irq_en <= bus.iomem_wdata[2];
        ctrl_led    <= bus.iomem_wdata[5:4];
      end
      if (wr_load) load_q <= byte_merge(load_q, bus.iomem_wdata, bus.iomem_wstrb);
      count_q <= count_d;
      // Expiry set beats a same-edge W1C so an event is never lost.
      if (expire)          expired_q <= 1'b1;
      else if (w1c_status) expired_q <= 1'b0;
    end
  end

  assign bus.iomem_ready = ready_q;
  assign bus.iomem_rdata = rdata_q;
  assign irq  = expired_q & ctrl_irq_en;
  assign led1 = ctrl_led[0];
  assign led2 = ctrl_led[1];

endmodule

// File: tb/tb_iomem_timer.sv
// Directed bench for iomem_timer: register access, timer modes, collisions, protocol corners.
module tb_iomem_timer;
  localparam logic [31:0] BASE = 32'h0300_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic irq, led1, led2;
  int   n_vec = 0;
  int   n_miss = 0;
  logic [31:0] rd;
  logic        seen;

  iomem_timer_if bus ();

  iomem_timer #(.BASE_ADDR(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .irq  (irq),
    .led1 (led1),
    .led2 (led2)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed running, expected done");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where ready is seen.
  task automatic xfer(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] wd,
                      output logic [31:0] data);
    int lat;
    if (bus.iomem_ready === 1'b1) @(negedge clk);
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = BASE | {24'h0, off};
    bus.iomem_wstrb = strb;
    bus.iomem_wdata = wd;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.iomem_ready !== 1'b1 && lat < 8);
    data = bus.iomem_rdata;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    chk("ready_latency", lat, 1);
  endtask

  task automatic wr(input logic [7:0] off, input logic [3:0] strb, input logic [31:0] wd);
    logic [31:0] dummy;
    xfer(off, strb, wd, dummy);
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] data;
    xfer(off, 4'h0, 32'h0, data);
    chk(tag, data, exp);
  endtask

  initial begin
    bus.iomem_valid = 1'b0;
    bus.iomem_addr  = 32'h0;
    bus.iomem_wstrb = 4'h0;
    bus.iomem_wdata = 32'h0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.iomem_ready), 32'h0);
    chk("rst_rdata", bus.iomem_rdata, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_leds", 32'({led2, led1}), 32'h0);
    reset = 1'b0;
    @(negedge clk);

    rd_chk("rst_ctrl", 8'h00, 32'h0);
    rd_chk("rst_load", 8'h04, 32'h0);
    rd_chk("rst_count", 8'h08, 32'h0);
    rd_chk("rst_status", 8'h0C, 32'h0);

    // Byte strobes and CTRL field masking
    wr(8'h04, 4'b0101, 32'hAABB_CCDD);
    rd_chk("load_strb", 8'h04, 32'h00BB_00DD);
    @(negedge clk);
    chk("rdata_idle_zero", bus.iomem_rdata, 32'h0);
    wr(8'h00, 4'hF, 32'h30);
    chk("leds_on", 32'({led2, led1}), 32'h3);
    rd_chk("ctrl_led_rd", 8'h00, 32'h30);
    wr(8'h00, 4'hF, 32'hFF);
    rd_chk("ctrl_mask", 8'h00, 32'h37);
    rd_chk("count_zero_hold", 8'h08, 32'h0);
    rd_chk("no_expiry_at_zero", 8'h0C, 32'h0);
    wr(8'h00, 4'hF, 32'h0);

    // Periodic mode: enable edge E0, expiries at E5 and E10
    wr(8'h04, 4'hF, 32'd5);
    wr(8'h08, 4'hF, 32'd5);
    rd_chk("count_written", 8'h08, 32'd5);
    wr(8'h00, 4'hF, 32'h07);
    repeat (4) @(negedge clk);
    chk("per_irq_before", 32'(irq), 32'h0);
    @(negedge clk);
    chk("per_irq_expire", 32'(irq), 32'h1);
    rd_chk("per_reload", 8'h08, 32'd5);
    wr(8'h0C, 4'h1, 32'h1);
    chk("per_w1c_irq", 32'(irq), 32'h0);
    @(negedge clk);
    chk("per_irq_e9", 32'(irq), 32'h0);
    @(negedge clk);
    chk("per_irq_e10", 32'(irq), 32'h1);
    wr(8'h00, 4'hF, 32'h0);
    wr(8'h0C, 4'h1, 32'h1);
    chk("per_irq_cleared", 32'(irq), 32'h0);
    rd_chk("count_frozen", 8'h08, 32'd4);

    // One-shot
    wr(8'h04, 4'hF, 32'd3);
    wr(8'h08, 4'hF, 32'd3);
    wr(8'h00, 4'hF, 32'h01);
    repeat (6) @(negedge clk);
    rd_chk("oneshot_count", 8'h08, 32'h0);
    rd_chk("oneshot_status", 8'h0C, 32'h1);
    rd_chk("oneshot_hold", 8'h08, 32'h0);

    // W1C landing on the expiry edge
    wr(8'h00, 4'hF, 32'h0);
    wr(8'h0C, 4'h1, 32'h1);
    wr(8'h08, 4'hF, 32'd3);
    wr(8'h00, 4'hF, 32'h01);
    @(negedge clk);
    @(negedge clk);
    wr(8'h0C, 4'h1, 32'h1);
    rd_chk("w1c_collide", 8'h0C, 32'h1);
    wr(8'h0C, 4'h1, 32'h1);
    rd_chk("w1c_clears", 8'h0C, 32'h0);

    // COUNT write on a decrement edge: 100 -> 99 -> write 0x50 -> 0x4F
    wr(8'h08, 4'hF, 32'd100);
    wr(8'h08, 4'hF, 32'h50);
    rd_chk("count_wr_wins", 8'h08, 32'h4F);

    // Valid pulse that never spans a rising edge
    @(posedge clk);
    #1;
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = BASE | 32'h04;
    bus.iomem_wstrb = 4'hF;
    bus.iomem_wdata = 32'h1234_5678;
    #3;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    @(negedge clk);
    @(negedge clk);
    chk("drop_no_ready", 32'(bus.iomem_ready), 32'h0);
    rd_chk("drop_no_write", 8'h04, 32'd3);

    // Outside the window
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = 32'h0400_0004;
    bus.iomem_wstrb = 4'h0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.iomem_ready !== 1'b0) seen = 1'b1;
    end
    bus.iomem_valid = 1'b0;
    chk("oow_no_ready", 32'(seen), 32'h0);

    // Reset between valid and ready
    bus.iomem_valid = 1'b1;
    bus.iomem_addr  = BASE | 32'h04;
    bus.iomem_wstrb = 4'hF;
    bus.iomem_wdata = 32'hDEAD_BEEF;
    #3;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", 32'(bus.iomem_ready), 32'h0);
    reset = 1'b0;
    bus.iomem_valid = 1'b0;
    bus.iomem_wstrb = 4'h0;
    @(negedge clk);
    rd_chk("rst_mid_load", 8'h04, 32'h0);
    rd_chk("rst_mid_ctrl", 8'h00, 32'h0);

    // Prescaler / offset 0x10
    wr(8'h04, 4'hF, 32'd2);
    wr(8'h08, 4'hF, 32'd2);
`ifdef IOMEM_TIMER_PRESCALER_EN
    wr(8'h10, 4'hF, 32'd3);
    wr(8'h00, 4'hF, 32'h05);
    repeat (7) @(negedge clk);
    chk("presc_irq_before", 32'(irq), 32'h0);
    @(negedge clk);
    chk("presc_irq_expire", 32'(irq), 32'h1);
    rd_chk("presc_rd", 8'h10, 32'd3);
`else
    wr(8'h00, 4'hF, 32'h05);
    @(negedge clk);
    chk("tick_irq_before", 32'(irq), 32'h0);
    @(negedge clk);
    chk("tick_irq_expire", 32'(irq), 32'h1);
    wr(8'h10, 4'hF, 32'h0000_FFFF);
    rd_chk("off10_reads_zero", 8'h10, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
